// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, MIPS field positions
// and PC arithmetic helpers.
package fetch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FETCH = ST_FETCH,
    FULL  = ST_FULL,
    DRAIN = ST_DRAIN
  } fetch_state_e;

  localparam int OPC_HI   = 31;
  localparam int OPC_LO   = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational splitter of a 32-bit MIPS instruction into its fields; shared
// with the decode stage.
module instr_field_split
  import fetch_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm16_o
);

  assign opcode_o = instr_i[OPC_HI:OPC_LO];
  assign rs_o     = instr_i[RS_HI:RS_LO];
  assign rt_o     = instr_i[RT_HI:RT_LO];
  assign rd_o     = instr_i[RD_HI:RD_LO];
  assign funct_o  = instr_i[FUNCT_HI:FUNCT_LO];
  assign imm16_o  = instr_i[IMM_HI:IMM_LO];

endmodule

// File: rtl/instr_fetch_stage.sv
// Single-outstanding instruction fetch stage: PC, req/ack memory port and a
// one-entry valid/ready output buffer towards decode.
module instr_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [5:0]  id_funct,
  output logic [15:0] id_imm16
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_addr_q, req_addr_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic [31:0]  redir_pc_s;

  assign redir_pc_s = word_align(redirect_pc);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      instr_q    <= 32'h0000_0000;
      id_pc_q    <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      instr_q    <= instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  // Next-state logic; a redirect while a request is outstanding must wait for
  // the stale ack (DRAIN) because the memory cannot cancel it.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    instr_d    = instr_q;
    id_pc_d    = id_pc_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect_valid) begin
          pc_d       = redir_pc_s;
          req_addr_d = redir_pc_s;
        end else begin
          req_addr_d = pc_q;
        end
      end
      FETCH: begin
        if (imem_ack && redirect_valid) begin
          pc_d       = redir_pc_s;
          req_addr_d = redir_pc_s;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          id_pc_d = req_addr_q;
          pc_d    = req_addr_q + PC_STEP;
          state_d = FULL;
        end else if (redirect_valid) begin
          pc_d    = redir_pc_s;
          state_d = DRAIN;
        end else begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (imem_ack) begin
          state_d = FETCH;
          if (redirect_valid) begin
            pc_d       = redir_pc_s;
            req_addr_d = redir_pc_s;
          end else begin
            req_addr_d = pc_q;
          end
        end else if (redirect_valid) begin
          pc_d = redir_pc_s;
        end else begin
          state_d = DRAIN;
        end
      end
      FULL: begin
        if (redirect_valid) begin
          pc_d       = redir_pc_s;
          req_addr_d = redir_pc_s;
          state_d    = FETCH;
        end else if (id_ready) begin
          req_addr_d = pc_q;
          state_d    = FETCH;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == FETCH) || (state_q == DRAIN);
  assign imem_addr   = req_addr_q;
  assign id_valid    = (state_q == FULL);
  assign id_instr    = instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_q + PC_STEP;

  instr_field_split u_split (
    .instr_i  (instr_q),
    .opcode_o (id_opcode),
    .rs_o     (id_rs),
    .rt_o     (id_rt),
    .rd_o     (id_rd),
    .funct_o  (id_funct),
    .imm16_o  (id_imm16)
  );

endmodule
